// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP controller: state codes, opcodes and
// the fixed instruction-register capture pattern.
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_TLR    = 4'hF,
        TAP_RTI    = 4'hC,
        TAP_SEL_DR = 4'h7,
        TAP_CAP_DR = 4'h6,
        TAP_SH_DR  = 4'h2,
        TAP_EX1_DR = 4'h1,
        TAP_PA_DR  = 4'h3,
        TAP_EX2_DR = 4'h0,
        TAP_UP_DR  = 4'h5,
        TAP_SEL_IR = 4'h4,
        TAP_CAP_IR = 4'hE,
        TAP_SH_IR  = 4'hA,
        TAP_EX1_IR = 4'h9,
        TAP_PA_IR  = 4'hB,
        TAP_EX2_IR = 4'h8,
        TAP_UP_IR  = 4'hD
    } tap_state_e;

    localparam logic [3:0] OPC_IDCODE = 4'h1;
    localparam logic [3:0] OPC_USER   = 4'h8;
    localparam logic [3:0] OPC_BYPASS = 4'hF;

    // Low two bits of the IR capture value; upper bits are always zero.
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine: next-state decode of tms plus the state register.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tms,
    output tap_state_e o_tap_state
);

    tap_state_e r_state;
    tap_state_e w_next;

    always_comb begin
        w_next = TAP_TLR;
        case (r_state)
            TAP_TLR:    w_next = i_tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: w_next = i_tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: w_next = i_tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  w_next = i_tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: w_next = i_tms ? TAP_UP_DR  : TAP_PA_DR;
            TAP_PA_DR:  w_next = i_tms ? TAP_EX2_DR : TAP_PA_DR;
            TAP_EX2_DR: w_next = i_tms ? TAP_UP_DR  : TAP_SH_DR;
            TAP_UP_DR:  w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: w_next = i_tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: w_next = i_tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  w_next = i_tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: w_next = i_tms ? TAP_UP_IR  : TAP_PA_IR;
            TAP_PA_IR:  w_next = i_tms ? TAP_EX2_IR : TAP_PA_IR;
            TAP_EX2_IR: w_next = i_tms ? TAP_UP_IR  : TAP_SH_IR;
            TAP_UP_IR:  w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
            default:    w_next = TAP_TLR;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= TAP_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_tap_state = r_state;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: instruction register, BYPASS/IDCODE/USER data registers
// and the combinational tdo mux, driven by the jtag_tap_fsm state.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter int          DR_WIDTH   = 16,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5A5B
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_tms,
    input  logic                i_tdi,
    output logic                o_tdo,
    output logic [3:0]          o_tap_state,
    output logic [IR_WIDTH-1:0] o_ir_out,
    input  logic [DR_WIDTH-1:0] i_user_dr_in,
    output logic [DR_WIDTH-1:0] o_user_dr_out,
    output logic                o_user_capture,
    output logic                o_user_update
);

    localparam logic [IR_WIDTH-1:0] W_OPC_IDCODE = IR_WIDTH'(OPC_IDCODE);
    localparam logic [IR_WIDTH-1:0] W_OPC_USER   = IR_WIDTH'(OPC_USER);
    localparam logic [IR_WIDTH-1:0] W_IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_LSBS);

    tap_state_e          w_state;
    logic [IR_WIDTH-1:0] r_ir_sr;
    logic [IR_WIDTH-1:0] r_ir;
    logic [IR_WIDTH-1:0] w_ir_active;
    logic                r_bypass;
    logic [31:0]         r_idcode_sr;
    logic [DR_WIDTH-1:0] r_user_sr;
    logic [DR_WIDTH-1:0] w_user_sr_next;
    logic [DR_WIDTH-1:0] r_user_dr_out;
    logic                w_sel_idcode;
    logic                w_sel_user;
    logic                w_sel_bypass;
    logic                w_tdo;

    jtag_tap_fsm u_fsm (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_tms       (i_tms),
        .o_tap_state (w_state)
    );

    // Test-Logic-Reset overrides the latched instruction immediately, not one edge later.
    assign w_ir_active  = (w_state == TAP_TLR) ? W_OPC_IDCODE : r_ir;
    assign w_sel_idcode = (w_ir_active == W_OPC_IDCODE);
    assign w_sel_user   = (w_ir_active == W_OPC_USER);
    assign w_sel_bypass = !w_sel_idcode && !w_sel_user;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ir_sr <= '0;
            r_ir    <= W_OPC_IDCODE;
        end else begin
            case (w_state)
                TAP_TLR:    r_ir    <= W_OPC_IDCODE;
                TAP_CAP_IR: r_ir_sr <= W_IR_CAPTURE;
                TAP_SH_IR:  r_ir_sr <= {i_tdi, r_ir_sr[IR_WIDTH-1:1]};
                TAP_UP_IR:  r_ir    <= r_ir_sr;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bypass <= 1'b0;
        end else if (w_sel_bypass) begin
            if (w_state == TAP_CAP_DR) begin
                r_bypass <= 1'b0;
            end else if (w_state == TAP_SH_DR) begin
                r_bypass <= i_tdi;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idcode_sr <= '0;
        end else if (w_sel_idcode) begin
            if (w_state == TAP_CAP_DR) begin
                r_idcode_sr <= IDCODE_VAL;
            end else if (w_state == TAP_SH_DR) begin
                r_idcode_sr <= {i_tdi, r_idcode_sr[31:1]};
            end
        end
    end

    // Built bit by bit so a one-bit user register needs no special-cased slice.
    generate
        for (genvar gi = 0; gi < DR_WIDTH; gi++) begin : g_user_shift
            if (gi == DR_WIDTH - 1) begin : g_msb
                assign w_user_sr_next[gi] = i_tdi;
            end else begin : g_lower
                assign w_user_sr_next[gi] = r_user_sr[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_user_sr     <= '0;
            r_user_dr_out <= '0;
        end else if (w_sel_user) begin
            case (w_state)
                TAP_CAP_DR: r_user_sr     <= i_user_dr_in;
                TAP_SH_DR:  r_user_sr     <= w_user_sr_next;
                TAP_UP_DR:  r_user_dr_out <= r_user_sr;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_tdo = 1'b0;
        case (w_state)
            TAP_SH_IR: w_tdo = r_ir_sr[0];
            TAP_SH_DR: begin
                if (w_sel_idcode) begin
                    w_tdo = r_idcode_sr[0];
                end else if (w_sel_user) begin
                    w_tdo = r_user_sr[0];
                end else begin
                    w_tdo = r_bypass;
                end
            end
            default: w_tdo = 1'b0;
        endcase
    end

    assign o_tdo          = w_tdo;
    assign o_tap_state    = w_state;
    assign o_ir_out       = w_ir_active;
    assign o_user_dr_out  = r_user_dr_out;
    assign o_user_capture = (w_state == TAP_CAP_DR) && w_sel_user;
    assign o_user_update  = (w_state == TAP_UP_DR) && w_sel_user;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: a table-driven TAP model checked every
// cycle, plus literal expectations on the serial read-outs.
module tb_jtag_tap_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_tms;
    logic        i_tdi;
    logic        o_tdo;
    logic [3:0]  o_tap_state;
    logic [3:0]  o_ir_out;
    logic [15:0] i_user_dr_in;
    logic [15:0] o_user_dr_out;
    logic        o_user_capture;
    logic        o_user_update;

    int total = 0;
    int bad   = 0;
    int cap_cnt = 0;
    int upd_cnt = 0;

    always #5 i_clk = ~i_clk;

    jtag_tap_ctrl #(
        .IR_WIDTH   (4),
        .DR_WIDTH   (16),
        .IDCODE_VAL (32'h1234_5A5B)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_tms          (i_tms),
        .i_tdi          (i_tdi),
        .o_tdo          (o_tdo),
        .o_tap_state    (o_tap_state),
        .o_ir_out       (o_ir_out),
        .i_user_dr_in   (i_user_dr_in),
        .o_user_dr_out  (o_user_dr_out),
        .o_user_capture (o_user_capture),
        .o_user_update  (o_user_update)
    );

    // ---------------- behavioural model ----------------
    logic [3:0]  nx0 [16];
    logic [3:0]  nx1 [16];
    logic [3:0]  m_state;
    logic [3:0]  m_ir;
    logic [3:0]  m_irsr;
    logic [63:0] m_dr;
    logic [15:0] m_udo;

    task automatic row(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
        nx0[s] = n0;
        nx1[s] = n1;
    endtask

    initial begin
        row(4'hF, 4'hC, 4'hF); row(4'hC, 4'hC, 4'h7);
        row(4'h7, 4'h6, 4'h4); row(4'h6, 4'h2, 4'h1);
        row(4'h2, 4'h2, 4'h1); row(4'h1, 4'h3, 4'h5);
        row(4'h3, 4'h3, 4'h0); row(4'h0, 4'h2, 4'h5);
        row(4'h5, 4'hC, 4'h7); row(4'h4, 4'hE, 4'hF);
        row(4'hE, 4'hA, 4'h9); row(4'hA, 4'hA, 4'h9);
        row(4'h9, 4'hB, 4'hD); row(4'hB, 4'hB, 4'h8);
        row(4'h8, 4'hA, 4'hD); row(4'hD, 4'hC, 4'h7);
    end

    function automatic int dr_len(input logic [3:0] ir);
        if (ir == 4'h1) return 32;
        if (ir == 4'h8) return 16;
        return 1;
    endfunction

    function automatic logic [63:0] dr_capture(input logic [3:0] ir, input logic [15:0] udin);
        if (ir == 4'h1) return 64'h1234_5A5B;
        if (ir == 4'h8) return {48'd0, udin};
        return 64'd0;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_state <= 4'hF;
            m_ir    <= 4'h1;
            m_irsr  <= 4'h0;
            m_dr    <= 64'd0;
            m_udo   <= 16'd0;
        end else begin
            m_state <= i_tms ? nx1[m_state] : nx0[m_state];
            if (m_state == 4'hF) m_ir <= 4'h1;
            if (m_state == 4'hE) m_irsr <= 4'b0001;
            if (m_state == 4'hA) m_irsr <= (m_irsr >> 1) | (i_tdi ? 4'h8 : 4'h0);
            if (m_state == 4'hD) m_ir <= m_irsr;
            if (m_state == 4'h6) m_dr <= dr_capture(m_ir, i_user_dr_in);
            if (m_state == 4'h2)
                m_dr <= (m_dr >> 1) | (i_tdi ? (64'd1 << (dr_len(m_ir) - 1)) : 64'd0);
            if (m_state == 4'h5 && m_ir == 4'h8) m_udo <= m_dr[15:0];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            chk("state", 64'(o_tap_state), 64'(m_state));
            chk("ir_out", 64'(o_ir_out), 64'((m_state == 4'hF) ? 4'h1 : m_ir));
            chk("tdo", 64'(o_tdo),
                64'((m_state == 4'hA) ? m_irsr[0] : (m_state == 4'h2) ? m_dr[0] : 1'b0));
            chk("user_dr_out", 64'(o_user_dr_out), 64'(m_udo));
            chk("user_capture", 64'(o_user_capture), 64'(m_state == 4'h6 && m_ir == 4'h8));
            chk("user_update", 64'(o_user_update), 64'(m_state == 4'h5 && m_ir == 4'h8));
        end
    end

    always @(negedge i_clk) begin
        if (o_user_capture) cap_cnt <= cap_cnt + 1;
        if (o_user_update)  upd_cnt <= upd_cnt + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic tms, input logic tdi, output logic tdo_s);
        i_tms = tms;
        i_tdi = tdi;
        #1 tdo_s = o_tdo;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic scan(input int n, input logic [63:0] din, output logic [63:0] dout);
        logic t;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], t);
            dout[i] = t;
        end
    endtask

    task automatic to_rti_from_ex1();
        logic t;
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
    endtask

    task automatic goto_shdr();
        logic t;
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
        step(1'b0, 1'b0, t);
    endtask

    task automatic goto_shir();
        logic t;
        step(1'b1, 1'b0, t);
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
        step(1'b0, 1'b0, t);
    endtask

    task automatic load_ir(input logic [3:0] v, output logic [63:0] readout);
        goto_shir();
        scan(4, 64'(v), readout);
        to_rti_from_ex1();
    endtask

    initial begin
        logic [63:0] out;
        logic        t;
        int          c0;
        int          u0;

        i_rst = 1'b1;
        i_tms = 1'b1;
        i_tdi = 1'b0;
        i_user_dr_in = 16'h0000;
        repeat (2) @(negedge i_clk);
        chk("rst_state", 64'(o_tap_state), 64'hF);
        chk("rst_ir", 64'(o_ir_out), 64'h1);
        chk("rst_tdo", 64'(o_tdo), 64'h0);
        chk("rst_udo", 64'(o_user_dr_out), 64'h0);
        i_rst = 1'b0;

        step(1'b0, 1'b0, t);
        chk("tlr_to_rti", 64'(o_tap_state), 64'hC);
        chk("rti_ir", 64'(o_ir_out), 64'h1);
        $display("txn reset->RTI state=%h ir=%h", o_tap_state, o_ir_out);

        goto_shdr();
        chk("shdr_state", 64'(o_tap_state), 64'h2);
        scan(32, 64'd0, out);
        chk("idcode_tdo", out, 64'h1234_5A5B);
        to_rti_from_ex1();
        $display("txn idcode scan tdo=%h", out[31:0]);

        load_ir(4'hF, out);
        chk("ir_cap_readout_2b", 64'(out[1:0]), 64'h1);
        chk("ir_cap_readout", out, 64'h1);
        chk("ir_bypass", 64'(o_ir_out), 64'hF);
        goto_shdr();
        scan(4, 64'b1101, out);
        chk("bypass_delay", out, 64'b1010);
        to_rti_from_ex1();
        $display("txn bypass scan in=1101 tdo=%b", out[3:0]);

        load_ir(4'h5, out);
        chk("ir_other", 64'(o_ir_out), 64'h5);
        goto_shdr();
        scan(3, 64'b011, out);
        chk("other_as_bypass", out, 64'b110);
        to_rti_from_ex1();
        $display("txn opcode 5 scan tdo=%b", out[2:0]);

        i_user_dr_in = 16'hBEEF;
        load_ir(4'h8, out);
        chk("ir_user", 64'(o_ir_out), 64'h8);
        c0 = cap_cnt;
        u0 = upd_cnt;
        goto_shdr();
        scan(16, 64'h1357, out);
        to_rti_from_ex1();
        chk("user_tdo", out, 64'hBEEF);
        chk("user_cap_pulses", 64'(cap_cnt - c0), 64'd1);
        chk("user_upd_pulses", 64'(upd_cnt - u0), 64'd1);
        chk("user_dr_out", 64'(o_user_dr_out), 64'h1357);
        $display("txn user scan tdo=%h dr_out=%h", out[15:0], o_user_dr_out);

        i_user_dr_in = 16'hA5C3;
        c0 = cap_cnt;
        u0 = upd_cnt;
        goto_shdr();
        out = '0;
        for (int i = 0; i < 7; i++) begin
            step(i == 6, 1'((16'h2468 >> i) & 1), t);
            out[i] = t;
        end
        step(1'b0, 1'b0, t);
        chk("pa_state", 64'(o_tap_state), 64'h3);
        step(1'b0, 1'b0, t);
        step(1'b0, 1'b0, t);
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
        chk("resume_shdr", 64'(o_tap_state), 64'h2);
        for (int i = 7; i < 16; i++) begin
            step(i == 15, 1'((16'h2468 >> i) & 1), t);
            out[i] = t;
        end
        to_rti_from_ex1();
        chk("pause_tdo", out, 64'hA5C3);
        chk("pause_dr_out", 64'(o_user_dr_out), 64'h2468);
        chk("pause_upd_pulses", 64'(upd_cnt - u0), 64'd1);
        $display("txn paused user scan tdo=%h dr_out=%h", out[15:0], o_user_dr_out);

        goto_shdr();
        step(1'b0, 1'b1, t);
        step(1'b0, 1'b1, t);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, t);
        chk("tms5_tlr", 64'(o_tap_state), 64'hF);
        chk("tms5_ir", 64'(o_ir_out), 64'h1);
        $display("txn 5x tms=1 state=%h ir=%h", o_tap_state, o_ir_out);

        step(1'b0, 1'b0, t);
        goto_shir();
        step(1'b0, 1'b1, t);
        step(1'b0, 1'b0, t);
        chk("pre_rst_shir", 64'(o_tap_state), 64'hA);
        u0 = upd_cnt;
        #2 i_rst = 1'b1;
        #1;
        chk("arst_state", 64'(o_tap_state), 64'hF);
        chk("arst_ir", 64'(o_ir_out), 64'h1);
        chk("arst_tdo", 64'(o_tdo), 64'h0);
        chk("arst_udo", 64'(o_user_dr_out), 64'h0);
        chk("arst_cap", 64'(o_user_capture), 64'h0);
        chk("arst_upd", 64'(o_user_update), 64'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
        chk("post_rst_rti", 64'(o_tap_state), 64'hC);
        chk("post_rst_no_upd", 64'(upd_cnt - u0), 64'd0);
        $display("txn async reset mid SH_IR state=%h dr_out=%h", o_tap_state, o_user_dr_out);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
